// File: rtl/uart_tx_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | uart_tx_arbiter_pkg : shared types and helpers for the arbiter   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_START = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_e;

   // Index width with a floor of one bit so degenerate sizes stay legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
// +------------------------------------------------------------------+
// | uart_tx_arbiter_rr_picker : combinational round-robin winner scan |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter_rr_picker
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = idx_width(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [ID_W-1:0] winner_o,
   output logic            any_o
);

   logic [ID_W-1:0] w_cand;

   // Scan from the far end back towards ptr_i so the closest set bit wins.
   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      w_cand   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_cand = ID_W'((int'(ptr_i) + k) % N);
         if (req_i[w_cand]) begin
            winner_o = w_cand;
            any_o    = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin sharing of one uart_tx serializer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_BITS  = 8,
   parameter  int WORD_BYTES = 4,
   localparam int ID_W       = idx_width(NUM_REQ),
   localparam int W          = WORD_BYTES * DATA_BITS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [NUM_REQ*W-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]     req_ack_o,
   output logic [NUM_REQ-1:0]     req_done_o,
   output logic                   tx_start_o,
   output logic [DATA_BITS-1:0]   tx_data_o,
   input  logic                   tx_done_tick_i,
   output logic                   busy_o,
   output logic [ID_W-1:0]        grant_id_o
);

   localparam int CNT_W = idx_width(WORD_BYTES);

   arb_state_e          state_q, state_d;
   logic [W-1:0]        shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ID_W-1:0]     owner_q, owner_d;
   logic [ID_W-1:0]     rr_q, rr_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [NUM_REQ-1:0]  done_q, done_d;

   logic [ID_W-1:0]     winner;
   logic                any_valid;

   uart_tx_arbiter_rr_picker #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_picker (
      .req_i    (req_valid_i),
      .ptr_i    (rr_q),
      .winner_o (winner),
      .any_o    (any_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         ack_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      ack_d      = '0;
      done_d     = '0;
      tx_start_o = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (any_valid) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (winner == ID_W'(i)) begin
                     shift_d = req_data_i[i*W +: W];
                  end
               end
               owner_d        = winner;
               cnt_d          = '0;
               ack_d[winner]  = 1'b1;
               state_d        = ARB_START;
            end
         end

         ARB_START: begin
            tx_start_o = 1'b1;
            state_d    = ARB_WAIT;
         end

         ARB_WAIT: begin
            if (tx_done_tick_i) begin
               if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                  done_d[owner_q] = 1'b1;
                  // The finished owner moves to the back of the scan order.
                  if (owner_q == ID_W'(NUM_REQ - 1)) begin
                     rr_d = '0;
                  end else begin
                     rr_d = owner_q + 1'b1;
                  end
                  state_d = ARB_IDLE;
               end else begin
                  shift_d = shift_q >> DATA_BITS;
                  cnt_d   = cnt_q + 1'b1;
                  state_d = ARB_START;
               end
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   assign tx_data_o  = shift_q[DATA_BITS-1:0];
   assign req_ack_o  = ack_q;
   assign req_done_o = done_q;
   assign busy_o     = (state_q != ARB_IDLE);
   assign grant_id_o = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed self-checking bench for the arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NR    = 4;
   localparam int W     = 32;
   localparam int FRAME = 6;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NR-1:0]   req_valid;
   logic [NR*W-1:0] req_data;
   logic [NR-1:0]   req_ack;
   logic [NR-1:0]   req_done;
   logic            tx_start;
   logic [7:0]      tx_data;
   logic            tx_done_tick;
   logic            busy;
   logic [1:0]      grant_id;

   logic model_tick = 1'b0;
   logic spur_tick  = 1'b0;

   logic [31:0] words [NR][4];
   int          nw [NR];
   int          hd [NR];
   int          acks [NR];
   int          dones [NR];

   logic [7:0]  frames [$];
   int          start_cyc [$];
   int          tick_cyc [$];
   int          grant_log [$];
   int          ack_cyc [$];
   int          done_cyc [$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ftimer = 0;

   always #5 clk = ~clk;

   assign tx_done_tick = model_tick | spur_tick;

   uart_tx_arbiter #(
      .NUM_REQ    (NR),
      .DATA_BITS  (8),
      .WORD_BYTES (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid_i    (req_valid),
      .req_data_i     (req_data),
      .req_ack_o      (req_ack),
      .req_done_o     (req_done),
      .tx_start_o     (tx_start),
      .tx_data_o      (tx_data),
      .tx_done_tick_i (tx_done_tick),
      .busy_o         (busy),
      .grant_id_o     (grant_id)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Requesters: each presents its queued words in order, holding valid until acked.
   always_comb begin
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < NR; i++) begin
         if (hd[i] < nw[i]) begin
            req_valid[i]       = 1'b1;
            req_data[i*W +: W] = words[i][hd[i]];
         end
      end
   end

   // uart_tx stand-in plus event logging.
   always @(negedge clk) begin
      model_tick = 1'b0;
      if (reset) begin
         ftimer = 0;
      end else if (tx_start) begin
         frames.push_back(tx_data);
         start_cyc.push_back(cyc);
         ftimer = FRAME;
      end else if (ftimer > 0) begin
         ftimer--;
         if (ftimer == 0) begin
            model_tick = 1'b1;
            tick_cyc.push_back(cyc);
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (req_ack[i]) begin
            acks[i]++;
            grant_log.push_back(i);
            ack_cyc.push_back(cyc);
            hd[i]++;
         end
         if (req_done[i]) begin
            dones[i]++;
            done_cyc.push_back(cyc);
         end
      end
   end

   task automatic clear_logs();
      frames.delete();
      start_cyc.delete();
      tick_cyc.delete();
      grant_log.delete();
      ack_cyc.delete();
      done_cyc.delete();
      for (int i = 0; i < NR; i++) begin
         nw[i] = 0; hd[i] = 0; acks[i] = 0; dones[i] = 0;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      bit pend;
      n = 0;
      pend = 1'b1;
      while ((busy || pend) && n < budget) begin
         @(negedge clk); #1;
         n++;
         pend = 1'b0;
         for (int i = 0; i < NR; i++) if (hd[i] < nw[i]) pend = 1'b1;
      end
      tests++;
      if (n >= budget) begin
         fails++;
         $display("FAIL wait_idle: timed out after %0d cycles (busy=%0b)", n, busy);
      end
   endtask

   function automatic logic [7:0] rr_byte(input int i, input int j, input int b);
      return 8'(i * 64 + j * 16 + b);
   endfunction

   task automatic test_reset();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      tests++; if (req_ack !== 4'b0) begin fails++; $display("FAIL reset_ack: got %0h expected 0", req_ack); end
      tests++; if (req_done !== 4'b0) begin fails++; $display("FAIL reset_done: got %0h expected 0", req_done); end
      tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %0b expected 0", tx_start); end
      tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
      @(negedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_single();
      int c0;
      clear_logs();
      words[0][0] = 32'h44332211;
      nw[0] = 1;
      c0 = cyc;
      wait_idle(200);
      tests++; if (frames.size() !== 4) begin fails++; $display("FAIL single_nframes: got %0d expected 4", frames.size()); end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (frames[k] !== 8'(8'h11 * (k + 1))) begin
            fails++; $display("FAIL single_frame%0d: got %0h expected %0h", k, frames[k], 8'(8'h11 * (k + 1)));
         end
      end
      tests++; if (acks[0] !== 1) begin fails++; $display("FAIL single_acks: got %0d expected 1", acks[0]); end
      tests++; if (dones[0] !== 1) begin fails++; $display("FAIL single_dones: got %0d expected 1", dones[0]); end
      tests++; if (ack_cyc[0] - c0 !== 1) begin fails++; $display("FAIL single_ack_latency: got %0d expected 1", ack_cyc[0] - c0); end
      tests++; if (start_cyc[0] !== ack_cyc[0]) begin fails++; $display("FAIL single_first_start: got cycle %0d expected %0d", start_cyc[0], ack_cyc[0]); end
      tests++; if (done_cyc[0] !== tick_cyc[3] + 1) begin fails++; $display("FAIL single_done_timing: got cycle %0d expected %0d", done_cyc[0], tick_cyc[3] + 1); end
   endtask

   task automatic test_round_robin();
      int exp_order [5];
      int j;
      exp_order = '{0, 1, 2, 3, 0};
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      clear_logs();
      for (int i = 0; i < NR; i++)
         for (int jj = 0; jj < 2; jj++)
            words[i][jj] = {rr_byte(i, jj, 3), rr_byte(i, jj, 2), rr_byte(i, jj, 1), rr_byte(i, jj, 0)};
      nw[0] = 2; nw[1] = 1; nw[2] = 1; nw[3] = 1;
      wait_idle(800);
      tests++; if (grant_log.size() !== 5) begin fails++; $display("FAIL rr_ngrants: got %0d expected 5", grant_log.size()); end
      tests++; if (frames.size() !== 20) begin fails++; $display("FAIL rr_nframes: got %0d expected 20", frames.size()); end
      for (int g = 0; g < 5; g++) begin
         tests++;
         if (grant_log[g] !== exp_order[g]) begin
            fails++; $display("FAIL rr_order%0d: got %0d expected %0d", g, grant_log[g], exp_order[g]);
         end
         j = (g == 4) ? 1 : 0;
         for (int b = 0; b < 4; b++) begin
            tests++;
            if (frames[g*4+b] !== rr_byte(exp_order[g], j, b)) begin
               fails++; $display("FAIL rr_frame%0d: got %0h expected %0h", g*4+b, frames[g*4+b], rr_byte(exp_order[g], j, b));
            end
         end
      end
      tests++; if (dones[0] !== 2) begin fails++; $display("FAIL rr_dones0: got %0d expected 2", dones[0]); end
      tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rr_grant_id: got %0d expected 0", grant_id); end
   endtask

   task automatic test_wrap();
      // Requester 3 finishes -> pointer wraps to 0, so 0 beats 3.
      clear_logs();
      words[3][0] = 32'h33333333; nw[3] = 1;
      wait_idle(200);
      clear_logs();
      words[0][0] = 32'hA0A0A0A0; nw[0] = 1;
      words[3][0] = 32'hA3A3A3A3; nw[3] = 1;
      wait_idle(400);
      tests++; if (grant_log.size() !== 2) begin fails++; $display("FAIL wrap_a_ngrants: got %0d expected 2", grant_log.size()); end
      tests++; if (grant_log[0] !== 0 || grant_log[1] !== 3) begin
         fails++; $display("FAIL wrap_a_order: got %0d,%0d expected 0,3", grant_log[0], grant_log[1]);
      end
      // Requester 2 finishes -> pointer at 3, so 3 beats 0 and the scan wraps to reach 0.
      clear_logs();
      words[2][0] = 32'h22222222; nw[2] = 1;
      wait_idle(200);
      clear_logs();
      words[0][0] = 32'hB0B0B0B0; nw[0] = 1;
      words[3][0] = 32'hB3B3B3B3; nw[3] = 1;
      wait_idle(400);
      tests++; if (grant_log[0] !== 3 || grant_log[1] !== 0) begin
         fails++; $display("FAIL wrap_b_order: got %0d,%0d expected 3,0", grant_log[0], grant_log[1]);
      end
      tests++; if (frames[4] !== 8'hB0) begin fails++; $display("FAIL wrap_b_frame4: got %0h expected b0", frames[4]); end
   endtask

   task automatic test_spurious();
      int n;
      clear_logs();
      spur_tick = 1'b1;
      @(negedge clk); #1;
      spur_tick = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL spur_idle_busy: got %0b expected 0", busy); end
      tests++; if (frames.size() !== 0) begin fails++; $display("FAIL spur_idle_frames: got %0d expected 0", frames.size()); end
      words[1][0] = 32'hDDCCBBAA; nw[1] = 1;
      n = 0;
      while (acks[1] == 0 && n < 20) begin @(negedge clk); #1; n++; end
      tests++; if (n >= 20) begin fails++; $display("FAIL spur_ack_wait: got no ack in %0d cycles expected ack", n); end
      spur_tick = 1'b1;
      @(negedge clk); #1;
      spur_tick = 1'b0;
      wait_idle(200);
      tests++; if (frames.size() !== 4) begin fails++; $display("FAIL spur_nframes: got %0d expected 4", frames.size()); end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (frames[k] !== 8'(8'hAA + 8'h11 * k)) begin
            fails++; $display("FAIL spur_frame%0d: got %0h expected %0h", k, frames[k], 8'(8'hAA + 8'h11 * k));
         end
      end
      tests++; if (dones[1] !== 1) begin fails++; $display("FAIL spur_dones: got %0d expected 1", dones[1]); end
   endtask

   task automatic test_reset_mid();
      int n;
      clear_logs();
      words[1][0] = 32'h87654321; nw[1] = 1;
      n = 0;
      while (frames.size() < 2 && n < 100) begin @(negedge clk); #1; n++; end
      tests++; if (n >= 100) begin fails++; $display("FAIL rstmid_wait: got %0d frames expected 2", frames.size()); end
      reset = 1'b1;
      @(negedge clk); #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
      tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rstmid_tx_start: got %0b expected 0", tx_start); end
      reset = 1'b0;
      repeat (FRAME + 4) @(negedge clk);
      #1;
      tests++; if (dones[1] !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d expected 0", dones[1]); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got %0b expected 0", busy); end
      clear_logs();
      words[2][0] = 32'h0D0C0B0A; nw[2] = 1;
      wait_idle(200);
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (frames[k] !== 8'(8'h0A + k)) begin
            fails++; $display("FAIL rstmid_next_frame%0d: got %0h expected %0h", k, frames[k], 8'(8'h0A + k));
         end
      end
      tests++; if (dones[2] !== 1) begin fails++; $display("FAIL rstmid_next_done: got %0d expected 1", dones[2]); end
   endtask

   task automatic test_back_to_back();
      clear_logs();
      words[2][0] = 32'h13121110;
      words[2][1] = 32'h17161514;
      nw[2] = 2;
      wait_idle(400);
      tests++; if (acks[2] !== 2) begin fails++; $display("FAIL b2b_acks: got %0d expected 2", acks[2]); end
      tests++; if (dones[2] !== 2) begin fails++; $display("FAIL b2b_dones: got %0d expected 2", dones[2]); end
      tests++; if (frames.size() !== 8) begin fails++; $display("FAIL b2b_nframes: got %0d expected 8", frames.size()); end
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (frames[k] !== 8'(8'h10 + k)) begin
            fails++; $display("FAIL b2b_frame%0d: got %0h expected %0h", k, frames[k], 8'(8'h10 + k));
         end
      end
      for (int k = 0; k < 7; k++) begin
         if (k != 3) begin
            tests++;
            if (start_cyc[k+1] - tick_cyc[k] !== 1) begin
               fails++; $display("FAIL b2b_gap%0d: got %0d expected 1", k, start_cyc[k+1] - tick_cyc[k]);
            end
         end
      end
      tests++; if (ack_cyc[1] !== done_cyc[0] + 1) begin
         fails++; $display("FAIL b2b_regrant: got cycle %0d expected %0d", ack_cyc[1], done_cyc[0] + 1);
      end
      tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL b2b_grant_id: got %0d expected 2", grant_id); end
   endtask

   initial begin
      clear_logs();
      repeat (3) @(negedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_spurious();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
